// File: rtl/encrypter_seq.sv
// 60-bit plaintext to 78-bit ciphertext frame encrypter: payload, 12-bit check, 6-bit selector.
// One word in flight; the LFSR-driven selector picks one of four transform schemes.
//
// state | meaning
// IDLE  | waiting for a plaintext word, in_ready high
// ENC   | transform latched plaintext into c
// CHK   | fold c into a 12-bit check, one slice per cycle (5 cycles)
// DONE  | frame presented, waiting for out_ready
module encrypter_seq #(
  parameter logic [59:0] KEY       = 60'h123456789ABCDEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] data_to_be_encrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] output_encrypted
);

  typedef enum logic [1:0] {IDLE, ENC, CHK, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t      state, state_next;
  logic [59:0] d_q, c_q;
  logic [5:0]  r_q;
  logic [11:0] chk_q;
  logic [2:0]  k_q;
  logic [15:0] lfsr_q;

  logic        accept;
  logic        lfsr_fb;
  logic [59:0] x_key, x_src, rot_out, rev_out, c_comb;
  logic [4:0]  rot_amt;
  logic [11:0] slice, chk_fold;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid;
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    x_key   = d_q ^ KEY;
    x_src   = (r_q[5:4] == 2'd1) ? d_q : x_key;
    rot_amt = {1'b0, r_q[3:0]} + 5'd1;
    rot_out = (x_src << rot_amt) | (x_src >> (6'd60 - {1'b0, rot_amt}));
    rev_out = '0;
    for (int i = 0; i < 60; i++) begin
      rev_out[i] = x_key[59-i];
    end
    case (r_q[5:4])
      2'd0:    c_comb = x_key;
      2'd1:    c_comb = rot_out;
      2'd2:    c_comb = rot_out;
      default: c_comb = rev_out;
    endcase
  end

  always_comb begin
    case (k_q)
      3'd0:    slice = c_q[11:0];
      3'd1:    slice = c_q[23:12];
      3'd2:    slice = c_q[35:24];
      3'd3:    slice = c_q[47:36];
      default: slice = c_q[59:48];
    endcase
    chk_fold = chk_q ^ slice;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ENC;
      ENC:     state_next = CHK;
      CHK:     if (k_q == 3'd4) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      d_q              <= '0;
      r_q              <= '0;
      c_q              <= '0;
      chk_q            <= '0;
      k_q              <= '0;
      lfsr_q           <= SEED_EFF;
      output_encrypted <= '0;
    end else begin
      if (accept) begin
        d_q    <= data_to_be_encrypt;
        r_q    <= lfsr_q[5:0];
        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      end
      if (state == ENC) begin
        c_q   <= c_comb;
        chk_q <= '0;
        k_q   <= '0;
      end
      if (state == CHK) begin
        chk_q <= chk_fold;
        k_q   <= k_q + 3'd1;
        if (k_q == 3'd4) output_encrypted <= {c_q, chk_fold, r_q};
      end
    end
  end

endmodule

// File: tb/tb_encrypter_seq.sv
// Bench for encrypter_seq: three instances with different LFSR seeds, a reference
// model feeding a per-instance scoreboard, plus fixed-value frame checks.
module tb_encrypter_seq;

  localparam logic [59:0] KEY   = 60'h123456789ABCDEF;
  localparam logic [47:0] SEEDS = {16'h0030, 16'h0005, 16'hACE1};
  localparam logic [77:0] FRAME_ZERO_DEF = {60'h48D159E26AF37BC, 12'h6BD, 6'h21};
  localparam logic [77:0] FRAME_KEY_S5   = {60'h0, 12'h000, 6'h05};
  localparam logic [77:0] FRAME_ZERO_S30 = {60'hF7B3D591E6A2C48, 12'hF5A, 6'h30};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv   [3];
  logic        ir   [3];
  logic [59:0] din  [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [77:0] dout [3];

  logic [77:0] sb_q [3][$];
  logic [15:0] m_lfsr [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    encrypter_seq #(.KEY(KEY), .LFSR_SEED(SEEDS[g*16 +: 16])) u_dut (
      .Clk                (clk),
      .Rst                (rst),
      .in_valid           (iv[g]),
      .in_ready           (ir[g]),
      .data_to_be_encrypt (din[g]),
      .out_valid          (ov[g]),
      .out_ready          (ordy[g]),
      .output_encrypted   (dout[g])
    );
  end

  task automatic check(input string tag, input logic [77:0] got, input logic [77:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  function automatic logic [15:0] seed_of(input int i);
    case (i)
      0:       return 16'hACE1;
      1:       return 16'h0005;
      default: return 16'h0030;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [77:0] model_frame(input logic [59:0] d, input logic [5:0] r);
    logic [59:0] x, c;
    logic [11:0] ck;
    int a;
    a = int'(r[3:0]) + 1;
    x = (r[5:4] == 2'd1) ? d : (d ^ KEY);
    c = '0;
    case (r[5:4])
      2'd0: c = x;
      2'd3: for (int i = 0; i < 60; i++) c[59-i] = x[i];
      default: for (int i = 0; i < 60; i++) c[(i + a) % 60] = x[i];
    endcase
    ck = '0;
    for (int s = 0; s < 5; s++)
      for (int b = 0; b < 12; b++) ck[b] = ck[b] ^ c[12*s + b];
    return {c, ck, r};
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (iv[i] === 1'b1 && ir[i] === 1'b1) begin
          sb_q[i].push_back(model_frame(din[i], m_lfsr[i][5:0]));
          m_lfsr[i] = lfsr_step(m_lfsr[i]);
        end
        if (ov[i] === 1'b1 && ordy[i] === 1'b1) begin
          if (sb_q[i].size() == 0) check("sb_unexpected_frame", 78'd0, 78'd1);
          else check("sb_frame", dout[i], sb_q[i].pop_front());
        end
      end
    end
  end

  task automatic assert_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q[i].delete();
      m_lfsr[i] = seed_of(i);
      iv[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 78'(ir[i]), 78'd1);
      check("rst_out_valid", 78'(ov[i]), 78'd0);
      check("rst_frame", dout[i], 78'd0);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    assert_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic send(input int i, input logic [59:0] d);
    int n = 0;
    while (ir[i] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("in_ready_timeout", 78'(ir[i]), 78'd1);
    din[i] = d;
    iv[i]  = 1'b1;
    @(posedge clk); #1;
    iv[i]  = 1'b0;
  endtask

  task automatic wait_out(input int i, output int n);
    n = 0;
    while (ov[i] !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    if (n >= 30) check("out_valid_timeout", 78'(ov[i]), 78'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [59:0] d;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; din[i] = '0; m_lfsr[i] = seed_of(i);
    end

    // reset mid-cycle, then default seed with plaintext 0
    apply_reset();
    ordy[0] = 1'b1;
    send(0, 60'h0);
    wait_out(0, n);
    check("latency", 78'(n), 78'd6);
    check("frame_zero_default", dout[0], FRAME_ZERO_DEF);
    @(posedge clk); #1;
    check("handshake_clears_valid", 78'(ov[0]), 78'd0);
    check("in_ready_after_handshake", 78'(ir[0]), 78'd1);

    // seed 5, plaintext KEY -> scheme 0
    ordy[1] = 1'b1;
    send(1, KEY);
    wait_out(1, n);
    check("frame_key_seed5", dout[1], FRAME_KEY_S5);
    @(posedge clk); #1;

    // backpressure with in_valid pressing during DONE
    apply_reset();
    ordy[0] = 1'b0;
    d = 60'hFEDCBA987654321;
    send(0, d);
    wait_out(0, n);
    din[0] = 60'h0F0F0F0F0F0F0F0;
    iv[0]  = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_frame_stable", dout[0], model_frame(d, 6'h21));
      check("bp_in_ready_low", 78'(ir[0]), 78'd0);
      check("bp_out_valid_held", 78'(ov[0]), 78'd1);
    end
    check("bp_no_second_accept", 78'(sb_q[0].size()), 78'd1);
    ordy[0] = 1'b1;
    n = 0;
    while (ir[0] !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_out(0, n);
    check("bp_r_one_step", 78'(dout[0][5:0]), 78'h03);
    check("bp_second_frame", dout[0], model_frame(60'h0F0F0F0F0F0F0F0, 6'h03));
    @(posedge clk); #1;

    // reset while folding the check field
    apply_reset();
    ordy[0] = 1'b1;
    send(0, 60'h0);
    repeat (4) @(posedge clk);
    #2;
    assert_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("no_output_after_reset", 78'(ov[0]), 78'd0);
    end
    send(0, 60'h0);
    wait_out(0, n);
    check("frame_after_reseed", dout[0], FRAME_ZERO_DEF);
    @(posedge clk); #1;

    // seed 0x30 -> scheme 3 bit reverse
    ordy[2] = 1'b1;
    send(2, 60'h0);
    wait_out(2, n);
    check("frame_zero_seed30", dout[2], FRAME_ZERO_S30);
    @(posedge clk); #1;

    // random words with random backpressure; scoreboard does the checking
    for (int w = 0; w < 10; w++) begin
      d = 60'({$urandom(), $urandom()});
      ordy[0] = 1'($urandom_range(0, 1));
      send(0, d);
      wait_out(0, n);
      if (ordy[0] == 1'b0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 ordy[0] = 1'b1;
      end
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("sb_drained", 78'(sb_q[i].size()), 78'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
